// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that hands requesters' operands to one
// shared sequential multiplier and returns the product to the served requester.
//
// Ports
//   clk          system clock, rising-edge
//   reset        asynchronous active-high reset
//   req[N]       level-sensitive multiply requests
//   a_in/b_in    packed operands, requester i at [i*BIT +: BIT]
//   gnt[N]       one-hot grant, held from LAUNCH through DONE
//   done[N]      one-cycle pulse for the served requester when result is valid
//   result       product of the last completed job (held until next DONE)
//   busy         high whenever the FSM is not IDLE
//   mul_start    one-cycle start strobe to the shared multiplier
//   mul_a/mul_b  operands latched at grant
//   mul_ready    multiplier idle/done flag, low while multiplying
//   mul_product  multiplier result, valid when mul_ready rises
//
// state  | meaning
// IDLE   | no job; arbitrate among req on each edge
// LAUNCH | operands latched, mul_start high this cycle
// ACK    | waiting for the multiplier to drop mul_ready
// BUSY   | waiting for mul_ready to return high, then capture product
// DONE   | done pulse for the granted requester; gnt clears on exit
//
// BIT is the operand width; only N=4 is supported.
module mult_arbiter #(
  parameter int BIT = 5,
  parameter int N   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*BIT-1:0] a_in,
  input  logic [N*BIT-1:0] b_in,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  output logic [2*BIT-1:0] result,
  output logic             busy,
  output logic             mul_start,
  output logic [BIT-1:0]   mul_a,
  output logic [BIT-1:0]   mul_b,
  input  logic             mul_ready,
  input  logic [2*BIT-1:0] mul_product
);

  localparam int IDXW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ACK    = 3'd2,
    BUSY   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [IDXW-1:0]   last, last_n;
  logic [N-1:0]      gnt_n, done_n;
  logic [2*BIT-1:0]  result_n;
  logic              busy_n, start_n;
  logic [BIT-1:0]    a_n, b_n;

  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW-1:0]   cand;

  // Search starts one past the last served index; k=N wraps back onto last,
  // so a lone persistent requester is still served.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last;
    cand       = last;
    for (int k = 1; k <= N; k++) begin
      cand = last + IDXW'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    done_n   = '0;
    start_n  = 1'b0;
    a_n      = mul_a;
    b_n      = mul_b;
    result_n = result;
    last_n   = last;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = LAUNCH;
          gnt_n   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          a_n     = a_in[pick_idx*BIT +: BIT];
          b_n     = b_in[pick_idx*BIT +: BIT];
          last_n  = pick_idx;
          start_n = 1'b1;
        end
      end
      LAUNCH: state_n = ACK;
      ACK: begin
        if (!mul_ready) state_n = BUSY;
      end
      BUSY: begin
        if (mul_ready) begin
          result_n = mul_product;
          done_n   = gnt;
          state_n  = DONE;
        end
      end
      DONE: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // All outputs are registered so nothing combinational reaches them from req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      result    <= '0;
      last      <= IDXW'(N-1);
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      done      <= done_n;
      busy      <= busy_n;
      mul_start <= start_n;
      mul_a     <= a_n;
      mul_b     <= b_n;
      result    <= result_n;
      last      <= last_n;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int BIT = 5;
  localparam int N   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*BIT-1:0] a_in = '0;
  logic [N*BIT-1:0] b_in = '0;
  logic [N-1:0]     gnt, done;
  logic [2*BIT-1:0] result;
  logic             busy, mul_start;
  logic [BIT-1:0]   mul_a, mul_b;
  logic             mul_ready;
  logic [2*BIT-1:0] mul_product;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    int               idx;
    logic [2*BIT-1:0] prod;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mult_arbiter #(.BIT(BIT), .N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  // Multiplier model: ready drops after start, stays low 6 cycles.
  int mcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      mcnt        <= 0;
    end else if (mul_start) begin
      mul_ready   <= 1'b0;
      mul_product <= mul_a * mul_b;
      mcnt        <= 6;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_ready <= 1'b1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
    end
  endfunction

  // Scoreboard monitor.
  int nstart = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      nstart = 0;
    end else begin
      if (mul_start) nstart++;
      if (done != 0) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_done: got done=%b, expected no done", done);
        end else begin
          e = exp_q.pop_front();
          chk("done_onehot", 32'(done), 32'(4'b0001 << e.idx));
          chk("result",      32'(result), 32'(e.prod));
          chk("gnt_in_done", 32'(gnt), 32'(done));
          chk("start_count", nstart, 1);
        end
        nstart = 0;
      end
    end
  end

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*BIT +: BIT] = BIT'(a);
    b_in[i*BIT +: BIT] = BIT'(b);
  endtask

  task automatic push(input int i, input int p);
    exp_t e;
    e.idx  = i;
    e.prod = (2*BIT)'(p);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string what);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done != 0) return;
    end
    tests++;
    errors++;
    $display("FAIL timeout_done_%s: got no done, expected done within 200 cycles", what);
  endtask

  task automatic wait_gnt(input string what);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt != 0) return;
    end
    tests++;
    errors++;
    $display("FAIL timeout_gnt_%s: got no gnt, expected gnt within 50 cycles", what);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(mul_start), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_result", 32'(result), 0);

    // Single request 13*11
    set_ops(0, 13, 11);
    push(0, 143);
    reset = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'b0001);
    chk("t1_start", 32'(mul_start), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_mul_a", 32'(mul_a), 13);
    chk("t1_mul_b", 32'(mul_b), 11);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_start_once", 32'(mul_start), 0);
    wait_done("t1");
    @(negedge clk);
    chk("t1_gnt_clr", 32'(gnt), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_result_hold", 32'(result), 143);

    // All requesting, including boundary operands
    set_ops(0, 3, 7);
    set_ops(1, 10, 12);
    set_ops(2, 31, 31);
    set_ops(3, 0, 31);
    push(0, 21); push(1, 120); push(2, 961); push(3, 0); push(0, 21);
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done("all");
    req = 4'b0000;
    @(negedge clk);

    // Hog: 0 and 1 requesting continuously
    set_ops(0, 2, 3);
    set_ops(1, 5, 6);
    push(0, 6); push(1, 30); push(0, 6); push(1, 30);
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 4; k++) wait_done("hog");
    req = 4'b0000;
    @(negedge clk);

    // Operand change during BUSY
    set_ops(0, 9, 9);
    push(0, 81);
    req = 4'b0001;
    wait_gnt("opchg");
    req = 4'b0000;
    repeat (4) @(negedge clk);
    set_ops(0, 1, 1);
    wait_done("opchg");
    @(negedge clk);

    // Reset mid-BUSY
    set_ops(1, 7, 7);
    req = 4'b0010;
    wait_gnt("rstmid");
    req = 4'b0000;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rm_gnt", 32'(gnt), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_done", 32'(done), 0);
    chk("rm_start", 32'(mul_start), 0);
    chk("rm_mul_a", 32'(mul_a), 0);
    chk("rm_mul_b", 32'(mul_b), 0);
    chk("rm_result", 32'(result), 0);
    repeat (3) @(negedge clk);
    set_ops(2, 6, 5);
    push(2, 30);
    reset = 1'b0;
    req = 4'b0100;
    @(negedge clk);
    chk("rm_first_gnt", 32'(gnt), 32'b0100);
    chk("rm_first_start", 32'(mul_start), 1);
    req = 4'b0000;
    wait_done("after_rst");
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
